// File: rtl/lcd_arb_pkg.sv
// Shared types and constants for the LCD access arbiter.
package lcd_arb_pkg;

  localparam int DATA_W           = 8;
  localparam int DELAY_W          = 32;
  localparam int WR_PULSE_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    SETTLE     = 2'd2,
    WAIT_READY = 2'd3
  } lcd_arb_state_e;

endpackage

// File: rtl/lcd_arb_rr_pick.sv
// Combinational round-robin picker: the first set req bit at or after start wins,
// with the search wrapping past the last requester.
module lcd_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    start,
  output logic [ID_W-1:0]    winner,
  output logic               valid
);

  logic [ID_W-1:0] cand [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cand[i] = ID_W'((int'(start) + i) % NUM_REQ);
    end
  end

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[cand[i]]) begin
        valid  = 1'b1;
        winner = cand[i];
      end
    end
  end

endmodule

// File: rtl/lcd_access_arbiter.sv
// Round-robin arbiter that shares one lcd_display write port among NUM_REQ requesters.
// Define LCD_ARB_LOCK_EN to let a locked, still-requesting owner keep the grant.
//
// Handshakes: a requester holds req until it sees ack. ack is a one-cycle pulse,
// given only in IDLE with disp_ready=1, in the same cycle the request is seen.
// The display side sees disp_write high for WR_PULSE cycles and then waits for
// disp_ready to come back.
module lcd_access_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WR_PULSE = WR_PULSE_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           lock,
  input  logic [DATA_W*NUM_REQ-1:0]    req_data,
  input  logic [NUM_REQ-1:0]           req_rs,
  input  logic [DELAY_W*NUM_REQ-1:0]   req_delay,
  input  logic [NUM_REQ-1:0]           req_b8,
  output logic [NUM_REQ-1:0]           ack,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic [DATA_W-1:0]            disp_data,
  output logic                         disp_rs,
  output logic [DELAY_W-1:0]           disp_delay,
  output logic                         disp_b8,
  output logic                         disp_write,
  input  logic                         disp_ready,
  output lcd_arb_state_e               dbg_state
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = 4;

  lcd_arb_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  start_idx, rr_winner, sel_id;
  logic             rr_valid, lock_hold, grant_go;

  assign start_idx = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  lcd_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .start  (start_idx),
    .winner (rr_winner),
    .valid  (rr_valid)
  );

`ifdef LCD_ARB_LOCK_EN
  assign lock_hold = lock[grant_id] & req[grant_id];
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign lock_hold   = 1'b0;
`endif

  // A lock only matters while its owner still requests, so rr_valid covers it.
  assign sel_id   = lock_hold ? grant_id : rr_winner;
  assign grant_go = rst_n && (state_q == IDLE) && disp_ready && rr_valid;

  always_comb begin
    ack = '0;
    if (grant_go) ack[sel_id] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_go) begin
          state_d = ISSUE;
          cnt_d   = '0;
        end
      end
      ISSUE: begin
        if (cnt_q == CNT_W'(WR_PULSE - 1)) state_d = SETTLE;
        else                               cnt_d   = cnt_q + CNT_W'(1);
      end
      SETTLE:     state_d = WAIT_READY;
      WAIT_READY: if (disp_ready) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Captured transfer fields stay put until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id   <= ID_W'(NUM_REQ - 1);
      disp_data  <= '0;
      disp_rs    <= 1'b0;
      disp_delay <= '0;
      disp_b8    <= 1'b0;
    end else if (grant_go) begin
      grant_id   <= sel_id;
      disp_data  <= req_data[DATA_W*sel_id +: DATA_W];
      disp_rs    <= req_rs[sel_id];
      disp_delay <= req_delay[DELAY_W*sel_id +: DELAY_W];
      disp_b8    <= req_b8[sel_id];
    end
  end

  // Decoded from the state register so an asynchronous reset drops it at once.
  assign disp_write = (state_q == ISSUE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lcd_access_arbiter.sv
// Self-checking bench for lcd_access_arbiter: directed cases plus randomized
// transfers compared against a transaction-level round-robin model.
module tb_lcd_access_arbiter;
  import lcd_arb_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int WR_PULSE = 2;
  localparam int ID_W     = $clog2(NUM_REQ);
`ifdef LCD_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic [NUM_REQ-1:0]          req = '0;
  logic [NUM_REQ-1:0]          lock = '0;
  logic [8*NUM_REQ-1:0]        req_data = '0;
  logic [NUM_REQ-1:0]          req_rs = '0;
  logic [32*NUM_REQ-1:0]       req_delay = '0;
  logic [NUM_REQ-1:0]          req_b8 = '0;
  logic [NUM_REQ-1:0]          ack;
  logic [ID_W-1:0]             grant_id;
  logic [7:0]                  disp_data;
  logic                        disp_rs;
  logic [31:0]                 disp_delay;
  logic                        disp_b8;
  logic                        disp_write;
  logic                        disp_ready = 1'b0;
  lcd_arb_state_e              dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_last = NUM_REQ - 1;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_data;
  logic        exp_rs, exp_b8;
  logic [31:0] exp_delay;

  lcd_access_arbiter #(.NUM_REQ(NUM_REQ), .WR_PULSE(WR_PULSE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .lock       (lock),
    .req_data   (req_data),
    .req_rs     (req_rs),
    .req_delay  (req_delay),
    .req_b8     (req_b8),
    .ack        (ack),
    .grant_id   (grant_id),
    .disp_data  (disp_data),
    .disp_rs    (disp_rs),
    .disp_delay (disp_delay),
    .disp_b8    (disp_b8),
    .disp_write (disp_write),
    .disp_ready (disp_ready),
    .dbg_state  (dbg_state)
  );

  // clock / reset / watchdog
  always #10 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: lock (when built in) keeps the owner, else next requester after last.
  function automatic int model_pick(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] l,
                                    input int last);
    if (LOCK_EN && l[last] && r[last]) return last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic randomize_payload();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[8*i +: 8]   = 8'($urandom);
      req_rs[i]            = 1'($urandom_range(0, 1));
      req_delay[32*i +: 32] = $urandom;
      req_b8[i]            = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_captured(input string tag);
    check({tag, "_data"},  disp_data,  exp_data);
    check({tag, "_rs"},    disp_rs,    exp_rs);
    check({tag, "_delay"}, disp_delay, exp_delay);
    check({tag, "_b8"},    disp_b8,    exp_b8);
  endtask

  // One full transfer; r must be nonzero. exp_id < 0 means no directed expectation.
  task automatic run_txn(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] l,
                         input int idle_wait, input int busy, input int exp_id);
    int w;
    int hi;
    @(negedge clk);
    req        = r;
    lock       = l;
    disp_ready = 1'b0;
    for (int i = 0; i < idle_wait; i++) begin
      #1 check("ack_not_ready", ack, '0);
      @(negedge clk);
    end
    disp_ready = 1'b1;
    #1;
    w = model_pick(r, l, exp_last);
    check("ack_grant", ack, 64'(1) << w);
    exp_q.push_back(req_data[8*w +: 8]);
    exp_rs    = req_rs[w];
    exp_delay = req_delay[32*w +: 32];
    exp_b8    = req_b8[w];
    @(posedge clk); #1;
    exp_last = w;
    exp_data = exp_q.pop_front();
    check("grant_id", grant_id, w);
    if (exp_id >= 0) check("grant_order", grant_id, exp_id);
    check("write_rise", disp_write, 1'b1);
    check_captured("capture");
    // Inputs changing outside IDLE must not disturb the transfer.
    disp_ready = 1'b0;
    req  = NUM_REQ'($urandom);
    lock = NUM_REQ'($urandom);
    randomize_payload();
    #1 check("ack_issue", ack, '0);
    hi = 1;
    for (int c = 0; c < 32; c++) begin
      @(posedge clk); #1;
      check("ack_busy", ack, '0);
      if (!disp_write) break;
      hi++;
    end
    check("pulse_width", hi, WR_PULSE);
    for (int c = 0; c <= busy; c++) begin
      @(posedge clk); #1;
      check("ack_wait", ack, '0);
      check("write_low", disp_write, 1'b0);
    end
    check_captured("stable");
    check("state_wait", dbg_state, WAIT_READY);
    disp_ready = 1'b1;
    req        = '0;
    @(posedge clk); #1;
    check("state_idle", dbg_state, IDLE);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"},   ack,        '0);
    check({tag, "_write"}, disp_write, 1'b0);
    check({tag, "_gid"},   grant_id,   NUM_REQ - 1);
    check({tag, "_data"},  disp_data,  '0);
    check({tag, "_rs"},    disp_rs,    1'b0);
    check({tag, "_delay"}, disp_delay, '0);
    check({tag, "_b8"},    disp_b8,    1'b0);
    check({tag, "_state"}, dbg_state,  IDLE);
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};

    // reset state
    req = 4'b1111;
    disp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    @(negedge clk);
    req = '0;
    rst_n = 1'b1;
    exp_last = NUM_REQ - 1;

    // first transfer to requester 0 with fixed payload
    randomize_payload();
    req_data[7:0]   = 8'h41;
    req_rs[0]       = 1'b1;
    req_delay[31:0] = 32'd20000;
    run_txn(4'b0001, 4'b0000, 0, 2, 0);
    check("dir_data",  disp_data,  8'h41);
    check("dir_rs",    disp_rs,    1'b1);
    check("dir_delay", disp_delay, 32'd20000);

    // reset during the first ISSUE cycle
    @(negedge clk);
    randomize_payload();
    req = 4'b0010;
    disp_ready = 1'b1;
    @(posedge clk); #1;
    check("mid_write_on", disp_write, 1'b1);
    req = '0;
    rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    exp_last = NUM_REQ - 1;
    @(posedge clk); #1;
    check("post_rst_ack", ack, '0);
    check("post_rst_state", dbg_state, IDLE);

    // all requesting: strict rotation
    for (int i = 0; i < 5; i++) begin
      randomize_payload();
      run_txn(4'b1111, 4'b0000, 0, $urandom_range(0, 3), order[i]);
    end

    // wrap-around from grant_id 3
    randomize_payload();
    run_txn(4'b1000, 4'b0000, 0, 1, 3);
    randomize_payload();
    run_txn(4'b1001, 4'b0000, 0, 1, 0);

    // ready low in IDLE holds the grant back
    randomize_payload();
    run_txn(4'b0100, 4'b0000, 3, 1, 2);

`ifdef LCD_ARB_LOCK_EN
    randomize_payload();
    run_txn(4'b0110, 4'b0010, 0, 1, 1);
    randomize_payload();
    run_txn(4'b0110, 4'b0010, 0, 1, 1);
    randomize_payload();
    run_txn(4'b0110, 4'b0010, 0, 1, 1);
    randomize_payload();
    run_txn(4'b0110, 4'b0000, 0, 1, 2);
`else
    randomize_payload();
    run_txn(4'b1001, 4'b0001, 0, 1, 3);
`endif

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      randomize_payload();
      run_txn(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), NUM_REQ'($urandom),
              $urandom_range(0, 2), $urandom_range(0, 4), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
